// File: rtl/high_frequency_apb_if.sv
// A-side APB bus bundle for the high_frequency_apb bridge.
// The master modport drives the request, the slave modport returns the response.
interface high_frequency_apb_if #(
    parameter int unsigned ADDR_WD = 32,
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned STRB_WD = 4,
    parameter int unsigned PROT_WD = 3
);
    logic               a_psel;
    logic               a_penable;
    logic               a_pwrite;
    logic [ADDR_WD-1:0] a_paddr;
    logic [DATA_WD-1:0] a_pwdata;
    logic [PROT_WD-1:0] a_pprot;
    logic [STRB_WD-1:0] a_pstrb;
    logic [DATA_WD-1:0] a_prdata;
    logic               a_pready;
    logic               a_pslverr;

    modport master (
        output a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_pprot, a_pstrb,
        input  a_prdata, a_pready, a_pslverr
    );

    modport slave (
        input  a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_pprot, a_pstrb,
        output a_prdata, a_pready, a_pslverr
    );
endinterface

// File: rtl/high_frequency_apb.sv
// A-domain end of the APB asynchronous bridge: toggle request out, toggle completion back.
// Optional macro APB_TIMEOUT_EN adds a WAIT-cycle timeout that completes with a_pslverr=1.
module high_frequency_apb #(
    parameter int unsigned ADDR_WD = 32,
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned STRB_WD = 4,
    parameter int unsigned PROT_WD = 3
`ifdef APB_TIMEOUT_EN
    ,parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic               a_pclk,
    input  logic               a_prst,
    high_frequency_apb_if.slave apb,
    output logic               a_apb_req,
    output logic               write,
    output logic [ADDR_WD-1:0] addr,
    output logic [DATA_WD-1:0] wdata,
    output logic [PROT_WD-1:0] prot,
    output logic [STRB_WD-1:0] strb,
    input  logic               b_ready_req,
    input  logic [DATA_WD-1:0] rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic               rdy_s1_q, rdy_s1_d;
    logic               rdy_s2_q, rdy_s2_d;
    logic               write_q, write_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic [DATA_WD-1:0] wdata_q, wdata_d;
    logic [PROT_WD-1:0] prot_q, prot_d;
    logic [STRB_WD-1:0] strb_q, strb_d;
    logic [DATA_WD-1:0] prdata_q, prdata_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_WD = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_WD-1:0]  cnt_q, cnt_d;
    logic               slverr_q, slverr_d;
`endif

    always_ff @(posedge a_pclk or posedge a_prst) begin
        if (a_prst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            rdy_s1_q <= 1'b0;
            rdy_s2_q <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            prot_q   <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q    <= '0;
            slverr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            rdy_s1_q <= rdy_s1_d;
            rdy_s2_q <= rdy_s2_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            prot_q   <= prot_d;
            strb_q   <= strb_d;
            prdata_q <= prdata_d;
`ifdef APB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            slverr_q <= slverr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        rdy_s1_d = b_ready_req;
        rdy_s2_d = rdy_s1_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        prot_d   = prot_q;
        strb_d   = strb_q;
        prdata_d = prdata_q;
`ifdef APB_TIMEOUT_EN
        cnt_d    = cnt_q;
        slverr_d = slverr_q;
`endif
        unique case (state_q)
            // a_psel alone (not only setup) launches, so a setup that stalled on a
            // stale timed-out request still launches from its held access phase.
            S_IDLE: begin
                if (apb.a_psel && (req_q == rdy_s2_q)) begin
                    write_d = apb.a_pwrite;
                    addr_d  = apb.a_paddr;
                    wdata_d = apb.a_pwdata;
                    prot_d  = apb.a_pprot;
                    strb_d  = apb.a_pstrb;
                    req_d   = ~req_q;
                    state_d = S_WAIT;
`ifdef APB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (rdy_s2_q == req_q) begin
                    if (!write_q) begin
                        prdata_d = rdata;
                    end
                    state_d = S_RESP;
`ifdef APB_TIMEOUT_EN
                    slverr_d = 1'b0;
                end else if (cnt_q == CNT_WD'(TIMEOUT_CYCLES - 1)) begin
                    slverr_d = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WD'(1);
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        apb.a_pready  = (state_q == S_RESP);
`ifdef APB_TIMEOUT_EN
        apb.a_pslverr = (state_q == S_RESP) && slverr_q;
`else
        apb.a_pslverr = 1'b0;
`endif
        apb.a_prdata  = prdata_q;
        a_apb_req     = req_q;
        write         = write_q;
        addr          = addr_q;
        wdata         = wdata_q;
        prot          = prot_q;
        strb          = strb_q;
    end

endmodule

// File: tb/tb_high_frequency_apb.sv
// Bench for high_frequency_apb: APB master stimulus, B-side toggle responder on a slow jittered
// clock, and scoreboards for A-side responses and B-side payloads.
`timescale 1ns/1ps
module tb_high_frequency_apb;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned PW = 3;
`ifdef APB_TIMEOUT_EN
    localparam int unsigned BH_MIN = 2;
    localparam int unsigned BH_MAX = 3;
`else
    localparam int unsigned BH_MIN = 30;
    localparam int unsigned BH_MAX = 40;
`endif

    typedef struct packed {
        logic [31:0] prdata;
        logic        pslverr;
    } resp_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  prot;
        logic [3:0]  strb;
    } pay_t;

    logic          a_pclk = 1'b0;
    logic          b_clk  = 1'b0;
    logic          a_prst = 1'b1;
    logic          a_apb_req;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [PW-1:0] prot;
    logic [SW-1:0] strb;
    logic          b_ready_req;
    logic [DW-1:0] rdata;

    high_frequency_apb_if #(.ADDR_WD(AW), .DATA_WD(DW), .STRB_WD(SW), .PROT_WD(PW)) apb_if ();

    high_frequency_apb #(
        .ADDR_WD(AW), .DATA_WD(DW), .STRB_WD(SW), .PROT_WD(PW)
`ifdef APB_TIMEOUT_EN
        ,.TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .a_pclk     (a_pclk),
        .a_prst     (a_prst),
        .apb        (apb_if.slave),
        .a_apb_req  (a_apb_req),
        .write      (write),
        .addr       (addr),
        .wdata      (wdata),
        .prot       (prot),
        .strb       (strb),
        .b_ready_req(b_ready_req),
        .rdata      (rdata)
    );

    always #5 a_pclk = ~a_pclk;
    initial forever begin
        #($urandom_range(BH_MAX, BH_MIN));
        b_clk = ~b_clk;
    end

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    resp_t       resp_q[$];
    pay_t        pay_q[$];
    pay_t        live;
    logic [31:0] model_prdata = '0;
    int unsigned n_xfer = 0;

    assign live = {write, addr, wdata, prot, strb};

    // B-side responder: sync request toggle, wait b_delay cycles, answer with next_rdata.
    int unsigned b_delay    = 0;
    logic [31:0] next_rdata = '0;
    int unsigned b_seen     = 0;
    logic        b_s1, b_s2, b_last, b_busy;
    int unsigned b_cnt;
    pay_t        b_cur;

    always @(posedge b_clk or posedge a_prst) begin
        if (a_prst) begin
            b_s1        <= 1'b0;
            b_s2        <= 1'b0;
            b_last      <= 1'b0;
            b_busy      <= 1'b0;
            b_cnt       <= 0;
            b_ready_req <= 1'b0;
            rdata       <= '0;
        end else begin
            b_s1 <= a_apb_req;
            b_s2 <= b_s1;
            if (!b_busy) begin
                if (b_s2 != b_last) begin
                    b_last <= b_s2;
                    b_busy <= 1'b1;
                    b_cnt  <= b_delay;
                    b_seen <= b_seen + 1;
                    if (pay_q.size() == 0) begin
                        check("b_spurious_req", pay_q.size(), 1);
                    end else begin
                        check("b_payload", live, pay_q[0]);
                        b_cur <= pay_q[0];
                        void'(pay_q.pop_front());
                    end
                end
            end else if (b_cnt == 0) begin
                check("b_payload_held", live, b_cur);
                rdata       <= next_rdata;
                b_ready_req <= ~b_ready_req;
                b_busy      <= 1'b0;
            end else begin
                b_cnt <= b_cnt - 1;
            end
        end
    end

    // Every launch must follow completion of all earlier launches.
    int unsigned tog_cnt, resp_cnt;
    logic        prev_req;
    always @(negedge a_pclk or posedge a_prst) begin
        if (a_prst) begin
            tog_cnt  <= 0;
            resp_cnt <= 0;
            prev_req <= 1'b0;
        end else begin
            if (a_apb_req != prev_req) begin
                check("launch_after_resp", resp_cnt, tog_cnt);
                tog_cnt <= tog_cnt + 1;
            end
            if (apb_if.a_pready) resp_cnt <= resp_cnt + 1;
            prev_req <= a_apb_req;
        end
    end

    task automatic xfer(input logic wr, input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] rd_sup, input int unsigned dly,
                        input logic exp_err, input logic exp_stall, output int unsigned ncyc);
        resp_t r;
        logic [2:0] pr;
        logic [3:0] st;
        logic       req_before;
        logic       got;
        pr = 3'($urandom);
        st = 4'($urandom);
        next_rdata = rd_sup;
        b_delay    = dly;
        r.pslverr  = exp_err;
        r.prdata   = (wr || exp_err) ? model_prdata : rd_sup;
        model_prdata = r.prdata;
        resp_q.push_back(r);
        pay_q.push_back({wr, ad, wd, pr, st});
        n_xfer++;
        @(posedge a_pclk);
        #1;
        apb_if.a_psel    = 1'b1;
        apb_if.a_penable = 1'b0;
        apb_if.a_pwrite  = wr;
        apb_if.a_paddr   = ad;
        apb_if.a_pwdata  = wd;
        apb_if.a_pprot   = pr;
        apb_if.a_pstrb   = st;
        req_before = a_apb_req;
        @(negedge a_pclk);
        check("pready_low_setup", apb_if.a_pready, 1'b0);
        @(posedge a_pclk);
        #1;
        apb_if.a_penable = 1'b1;
        ncyc = 0;
        got  = 1'b0;
        while (!got && ncyc < 4000) begin
            @(negedge a_pclk);
            ncyc++;
            if (exp_stall && ncyc == 1) check("stall_no_launch", a_apb_req, req_before);
            if (apb_if.a_pready) got = 1'b1;
        end
        if (!got) begin
            check("pready_timeout", apb_if.a_pready, 1'b1);
        end else begin
            r = resp_q.pop_front();
            check("prdata", apb_if.a_prdata, r.prdata);
            check("pslverr", apb_if.a_pslverr, r.pslverr);
        end
    endtask

    task automatic idle();
        @(posedge a_pclk);
        #1;
        apb_if.a_psel    = 1'b0;
        apb_if.a_penable = 1'b0;
        @(negedge a_pclk);
        check("pready_one_cycle", apb_if.a_pready, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned nc;
        int unsigned t0;
        int unsigned seen0;
        logic        wr;
        apb_if.a_psel    = 1'b0;
        apb_if.a_penable = 1'b0;
        apb_if.a_pwrite  = 1'b0;
        apb_if.a_paddr   = '0;
        apb_if.a_pwdata  = '0;
        apb_if.a_pprot   = '0;
        apb_if.a_pstrb   = '0;
        repeat (3) @(posedge a_pclk);
        @(negedge a_pclk);
        check("rst_apb_req", a_apb_req, 1'b0);
        check("rst_pready", apb_if.a_pready, 1'b0);
        check("rst_pslverr", apb_if.a_pslverr, 1'b0);
        check("rst_prdata", apb_if.a_prdata, 32'h0);
        check("rst_payload", live, '0);
        @(posedge a_pclk);
        #1 a_prst = 1'b0;

        xfer(1'b1, 32'h10, 32'hA5A5_0001, 32'h0, 5, 1'b0, 1'b0, nc);
        idle();
        check("b_seen_first", b_seen, 1);
        check("write_payload", {write, addr, wdata}, {1'b1, 32'h10, 32'hA5A5_0001});

        xfer(1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, nc);
        idle();

        t0 = tog_cnt;
        xfer(1'b1, 32'h30, 32'h1111_2222, 32'h0, 1, 1'b0, 1'b0, nc);
        xfer(1'b0, 32'h34, 32'h0, 32'h3333_4444, 2, 1'b0, 1'b0, nc);
        idle();
        check("b2b_toggles", tog_cnt - t0, 2);

        for (int i = 0; i < 1000; i++) begin
            wr = 1'($urandom);
            xfer(wr, $urandom, $urandom, $urandom, $urandom_range(3, 0), 1'b0, 1'b0, nc);
            if ($urandom_range(1, 0) == 1) idle();
        end
        idle();
        check("b_seen_total", b_seen, n_xfer);
        check("toggle_total", tog_cnt, n_xfer);

`ifdef APB_TIMEOUT_EN
        xfer(1'b0, 32'h40, 32'h0, 32'h0BAD_0BAD, 60, 1'b1, 1'b0, nc);
        check("timeout_cycles", nc, 17);
        xfer(1'b0, 32'h44, 32'h0, 32'h1234_5678, 2, 1'b0, 1'b1, nc);
        idle();
        check("timeout_b_seen", b_seen, n_xfer);
`endif

        // Reset during WAIT: wait for B to take the request, then reset both domains.
        seen0 = b_seen;
        pay_q.push_back({1'b0, 32'h50, 32'h0, 3'h0, 4'h0});
        next_rdata = 32'h7777_7777;
        b_delay    = 50;
        @(posedge a_pclk);
        #1;
        apb_if.a_psel    = 1'b1;
        apb_if.a_penable = 1'b0;
        apb_if.a_pwrite  = 1'b0;
        apb_if.a_paddr   = 32'h50;
        apb_if.a_pwdata  = 32'h0;
        apb_if.a_pprot   = 3'h0;
        apb_if.a_pstrb   = 4'h0;
        @(posedge a_pclk);
        #1 apb_if.a_penable = 1'b1;
        for (int k = 0; k < 400 && b_seen == seen0; k++) @(negedge a_pclk);
        check("rst_test_b_capture", b_seen, seen0 + 1);
        check("wait_pready_low", apb_if.a_pready, 1'b0);
        #2 a_prst = 1'b1;
        #1;
        check("arst_apb_req", a_apb_req, 1'b0);
        check("arst_pready", apb_if.a_pready, 1'b0);
        check("arst_pslverr", apb_if.a_pslverr, 1'b0);
        check("arst_prdata", apb_if.a_prdata, 32'h0);
        check("arst_payload", live, '0);
        apb_if.a_psel    = 1'b0;
        apb_if.a_penable = 1'b0;
        repeat (3) @(posedge a_pclk);
        #1 a_prst = 1'b0;
        model_prdata = '0;
        xfer(1'b0, 32'h54, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 1'b0, nc);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
